// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target endpoint (and the matching controller).
// Holds the target FSM state enum and the bit-level ACK/NACK constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        TGT_IDLE,
        TGT_ADDR,
        TGT_ADDR_ACK,
        TGT_RX,
        TGT_RX_ACK,
        TGT_TX,
        TGT_TX_ACK,
        TGT_IGNORE
    } i2c_tgt_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Bus + register-side bundle of the I2C target.
//   scl_i, sda_i : raw pad inputs (asynchronous)
//   sda_oe       : 1 = pull SDA low, 0 = release
//   rx_data/rx_valid : received write byte and its one-cycle strobe
//   tx_data/tx_req   : read byte and its one-cycle request/consume strobe
//   busy, stop_det   : transaction status and STOP pulse
// slave  = the target's view, master = the environment's view.
interface i2c_target_if #(
    parameter int data_wd = 8
);
    logic               scl_i;
    logic               sda_i;
    logic               sda_oe;
    logic [data_wd-1:0] rx_data;
    logic               rx_valid;
    logic [data_wd-1:0] tx_data;
    logic               tx_req;
    logic               busy;
    logic               stop_det;

    modport slave (
        input  scl_i, sda_i, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, stop_det
    );

    modport master (
        output scl_i, sda_i, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, stop_det
    );
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers plus one history stage for SCL/SDA, and the
// bus-event flags derived from the last two synchronized samples.
// Ports:
//   clk, rst            : system clock, async active-high reset
//   scl_raw, sda_raw    : asynchronous pad levels
//   scl_rise, scl_fall  : one-cycle SCL edge flags
//   start_det, stop_det : SDA fall / rise while SCL held high
//   sda                 : synchronized SDA level
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);
    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    // Reset to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            // p0/p1: synchronizer, p2: history
            scl_p0 <= scl_raw;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_raw;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    // SCL must be high in both samples so an SDA change coinciding with
    // an SCL edge is treated as data, not as a bus condition.
    assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;
    assign sda       =  sda_p1;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint. Oversamples the bus, decodes START/STOP, matches
// own_addr, ACKs, and moves bytes to/from the register file.
// Ports:
//   clk  : system clock (>= 8x SCL)
//   rst  : asynchronous active-high reset
//   bus  : i2c_target_if.slave (pad lines, rx/tx byte handshake, status)
module i2c_target
    import i2c_pkg::*;
#(
    parameter int                 data_wd  = 8,
    parameter int                 addr_wd  = 7,
    parameter logic [addr_wd-1:0] own_addr = 7'h42
) (
    input  logic         clk,
    input  logic         rst,
    i2c_target_if.slave  bus
);
    localparam logic [3:0] LAST_BIT = 4'(data_wd - 1);
    localparam logic [3:0] ALL_BITS = 4'(data_wd);

    logic scl_rise, scl_fall, start_det, stop_det, sda;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_raw   (bus.scl_i),
        .sda_raw   (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda       (sda)
    );

    i2c_tgt_state_e     state, state_next;
    logic [3:0]         bit_cnt, bit_cnt_next;
    logic [data_wd-1:0] shift, shift_next;
    logic               rw, rw_next;
    logic               ack_in, ack_next;
    logic               sda_oe_q, oe_next;
    logic [data_wd-1:0] rx_data_q, rx_data_next;
    logic               rx_valid_q, rx_valid_next;
    logic               busy_q, busy_next;
    logic               tx_req;

    logic [data_wd-1:0] shift_in;
    logic               addr_hit;

    assign shift_in = {shift[data_wd-2:0], sda};
    assign addr_hit = (shift_in[data_wd-1 -: addr_wd] == own_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TGT_IDLE;
        else     state <= state_next;
    end

    // The ACK phases use sda_oe itself as the phase marker: the first SCL
    // fall finds it low (assert ACK), the second finds it high (finish).
    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = TGT_IDLE;
        end else if (start_det) begin
            state_next = TGT_ADDR;
        end else begin
            case (state)
                TGT_ADDR:
                    if (scl_rise && bit_cnt == LAST_BIT)
                        state_next = addr_hit ? TGT_ADDR_ACK : TGT_IGNORE;
                TGT_ADDR_ACK:
                    if (scl_fall && sda_oe_q)
                        state_next = rw ? TGT_TX : TGT_RX;
                TGT_RX:
                    if (scl_rise && bit_cnt == LAST_BIT)
                        state_next = TGT_RX_ACK;
                TGT_RX_ACK:
                    if (scl_fall && sda_oe_q)
                        state_next = TGT_RX;
                TGT_TX:
                    if (scl_fall && bit_cnt == ALL_BITS)
                        state_next = TGT_TX_ACK;
                TGT_TX_ACK:
                    if (scl_fall)
                        state_next = (ack_in == I2C_ACK) ? TGT_TX : TGT_IGNORE;
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_req        = 1'b0;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        rw_next       = rw;
        ack_next      = ack_in;
        oe_next       = sda_oe_q;
        rx_data_next  = rx_data_q;
        rx_valid_next = 1'b0;
        busy_next     = busy_q;
        if (stop_det) begin
            // Any partial byte is simply dropped with the counter.
            oe_next      = 1'b0;
            busy_next    = 1'b0;
            bit_cnt_next = 4'd0;
        end else if (start_det) begin
            oe_next      = 1'b0;
            bit_cnt_next = 4'd0;
        end else begin
            case (state)
                TGT_ADDR: begin
                    if (scl_rise) begin
                        shift_next = shift_in;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_next = 4'd0;
                            rw_next      = shift_in[0];
                            busy_next    = addr_hit;
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                TGT_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            oe_next = 1'b1;
                        end else if (rw) begin
                            // First read byte is fetched on the same fall
                            // that ends the address ACK.
                            tx_req     = 1'b1;
                            shift_next = bus.tx_data;
                            oe_next    = ~bus.tx_data[data_wd-1];
                        end else begin
                            oe_next = 1'b0;
                        end
                    end
                end
                TGT_RX: begin
                    if (scl_rise) begin
                        shift_next = shift_in;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_next  = 4'd0;
                            rx_data_next  = shift_in;
                            rx_valid_next = 1'b1;
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                TGT_RX_ACK: begin
                    if (scl_fall)
                        oe_next = ~sda_oe_q;
                end
                TGT_TX: begin
                    // bit_cnt counts rises; the MSB went out on entry, so
                    // each later fall presents the next bit until all 8 are done.
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == ALL_BITS) begin
                            oe_next      = 1'b0;
                            bit_cnt_next = 4'd0;
                        end else begin
                            shift_next = {shift[data_wd-2:0], 1'b0};
                            oe_next    = ~shift[data_wd-2];
                        end
                    end
                end
                TGT_TX_ACK: begin
                    if (scl_rise) begin
                        ack_next = sda;
                    end else if (scl_fall) begin
                        if (ack_in == I2C_ACK) begin
                            tx_req     = 1'b1;
                            shift_next = bus.tx_data;
                            oe_next    = ~bus.tx_data[data_wd-1];
                        end else begin
                            oe_next = 1'b0;
                        end
                    end
                end
                TGT_IGNORE: oe_next = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            shift      <= '0;
            rw         <= 1'b0;
            ack_in     <= I2C_NACK;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            rw         <= rw_next;
            ack_in     <= ack_next;
            sda_oe_q   <= oe_next;
            rx_data_q  <= rx_data_next;
            rx_valid_q <= rx_valid_next;
            busy_q     <= busy_next;
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req;
    assign bus.busy     = busy_q;
    assign bus.stop_det = stop_det;

endmodule

// File: tb/tb_i2c_target.sv
// Randomized bench for i2c_target: a bit-level bus controller drives the
// open-drain lines, and expected bus/handshake behaviour is derived from the
// transaction (address hit, direction, payload) rather than from the RTL.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int         Q        = 4;      // clk cycles per SCL quarter
    localparam logic [6:0] OWN_ADDR = 7'h42;

    logic clk = 1'b0;
    logic rst;
    logic scl_drv, sda_drv;

    always #5 clk = ~clk;

    i2c_target_if #(.data_wd(8)) bus ();

    i2c_target #(.data_wd(8), .addr_wd(7), .own_addr(OWN_ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Open-drain wired-AND of controller and target.
    assign bus.scl_i = scl_drv;
    assign bus.sda_i = sda_drv & ~bus.sda_oe;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitors / register-file side ----------------
    logic [7:0] rx_log[$];
    logic [7:0] tx_q[$];
    logic [7:0] pay[$];
    int  rx_cnt = 0, tx_cnt = 0, stop_cnt = 0, oe_cyc = 0, tx_idx = 0;
    logic adv = 1'b0;

    always @(negedge clk) begin
        if (adv) begin
            tx_idx++;
            adv = 1'b0;
        end
        if (bus.rx_valid) begin
            rx_cnt++;
            rx_log.push_back(bus.rx_data);
        end
        if (bus.tx_req) begin
            tx_cnt++;
            adv = 1'b1;
        end
        if (bus.stop_det) stop_cnt++;
        if (bus.sda_oe)   oe_cyc++;
        bus.tx_data = (tx_idx < tx_q.size()) ? tx_q[tx_idx] : 8'h00;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bus controller ----------------
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    // Works both from idle and as a repeated START with SCL low.
    task automatic bus_start();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q(); wait_q();
    endtask

    task automatic xfer_bit(input logic b, output logic r, output logic oe);
        sda_drv = b;    wait_q();
        scl_drv = 1'b1; wait_q();
        r  = bus.sda_i;
        oe = bus.sda_oe;
        wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r, oe;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], r, oe);
        xfer_bit(1'b1, ack, oe);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r, oe;
        for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i], oe);
        xfer_bit(nack, r, oe);
        chk("tx_ack_oe_released", oe, 1'b0);
    endtask

    // START + address + payload from pay[]; expectations follow from
    // whether the address is ours and from the direction bit.
    task automatic txn(input logic [6:0] addr, input logic rw);
        logic       a;
        logic [7:0] d;
        int  n    = pay.size();
        bit  hit  = (addr == OWN_ADDR);
        int  rx0  = rx_cnt, tx0 = tx_cnt, oe0 = oe_cyc;
        int  base = rx_log.size();
        if (hit && rw) foreach (pay[i]) tx_q.push_back(pay[i]);
        bus_start();
        send_byte({addr, rw}, a);
        chk("addr_ack", a, hit ? I2C_ACK : I2C_NACK);
        chk("busy_after_addr", bus.busy, hit);
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                send_byte(pay[i], a);
                chk("data_ack", a, hit ? I2C_ACK : I2C_NACK);
            end
            chk("rx_valid_count", rx_cnt - rx0, hit ? n : 0);
            if (hit) begin
                for (int i = 0; i < n; i++) chk("rx_byte", rx_log[base + i], pay[i]);
                chk("rx_data_held", bus.rx_data, pay[n-1]);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                recv_byte(i == n - 1, d);
                chk("rd_byte", d, hit ? pay[i] : 8'hFF);
            end
            chk("tx_req_count", tx_cnt - tx0, hit ? n : 0);
        end
        if (!hit) chk("oe_quiet", oe_cyc - oe0, 0);
    endtask

    task automatic stop_chk();
        int s0 = stop_cnt;
        bus_stop();
        chk("stop_pulse", stop_cnt - s0, 1);
        chk("busy_idle", bus.busy, 1'b0);
        chk("oe_idle", bus.sda_oe, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_sda_oe", bus.sda_oe, 1'b0);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 1'b0);
        chk("rst_tx_req", bus.tx_req, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_stop_det", bus.stop_det, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       a, r, oe;
        logic [7:0] keep;
        int         rx0;

        rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write to own address
        pay = '{8'hA5};
        txn(OWN_ADDR, 1'b0);
        stop_chk();

        // Foreign address
        pay = '{8'h11};
        txn(7'h43, 1'b0);
        stop_chk();

        // Two-byte read, ACK then NACK
        pay = '{8'h3C, 8'hC3};
        txn(OWN_ADDR, 1'b1);
        stop_chk();

        // Write, repeated START, read
        pay = '{8'h5A};
        txn(OWN_ADDR, 1'b0);
        pay = '{8'($urandom)};
        txn(OWN_ADDR, 1'b1);
        stop_chk();

        // STOP in the middle of a data byte
        keep = bus.rx_data;
        rx0  = rx_cnt;
        bus_start();
        send_byte({OWN_ADDR, 1'b0}, a);
        chk("partial_addr_ack", a, I2C_ACK);
        for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), r, oe);
        stop_chk();
        chk("partial_no_rx_valid", rx_cnt - rx0, 0);
        chk("partial_rx_data_kept", bus.rx_data, keep);
        pay = '{8'h96};
        txn(OWN_ADDR, 1'b0);
        stop_chk();

        // Asynchronous reset while the target holds the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) xfer_bit(i == 0 ? 1'b0 : OWN_ADDR[i-1], r, oe);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; repeat (2) @(negedge clk);
        chk("ack_driven_before_rst", bus.sda_oe, 1'b1);
        #1 rst = 1'b1;
        #1 chk_reset_outputs();
        @(negedge clk) rst = 1'b0;
        wait_q();
        scl_drv = 1'b0; wait_q();
        bus_stop();
        pay = '{8'h24, 8'hE7};
        txn(OWN_ADDR, 1'b0);
        stop_chk();

        // Random transactions
        for (int t = 0; t < 14; t++) begin
            logic [6:0] addr;
            logic       rw;
            int         n;
            addr = ($urandom_range(0, 3) == 0) ? (OWN_ADDR ^ 7'($urandom_range(1, 127))) : OWN_ADDR;
            rw   = 1'($urandom_range(0, 1));
            n    = $urandom_range(1, 3);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            txn(addr, rw);
            stop_chk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
